regfile_wb_sb: RTL and testbench

- Register file that sits at the far end of the write-back stage: captures the selected write-back result and serves operands to decode/execute.
- Two combinational read ports and one write port fed by the write-back mux output.
- Includes a per-register load scoreboard: a load marks its destination pending at issue, and the load write-back clears it. Decode stalls on any pending source.

---
 rtl/regfile_wb_sb_if.sv | 37 +++
 rtl/regfile_wb_sb.sv | 101 ++++++++++
 tb/tb_regfile_wb_sb.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_sb_if.sv
// Bundle for regfile_wb_sb: write-back port, load-issue/flush scoreboard
// controls, two read ports and status. The pipeline side uses "master";
// the register file uses "slave".
interface regfile_wb_sb_if #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3
);
  logic                wb_en;
  logic [ADDR_W-1:0]   wb_addr;
  logic [DATA_W-1:0]   wb_data;
  logic                wb_ld_sel;
  logic                ld_issue;
  logic [ADDR_W-1:0]   ld_issue_addr;
  logic                flush;
  logic [ADDR_W-1:0]   rs1_addr;
  logic [ADDR_W-1:0]   rs2_addr;
  logic [DATA_W-1:0]   rs1_data;
  logic [DATA_W-1:0]   rs2_data;
  logic                stall;
  logic [NUM_REGS-1:0] pending;
  logic                sb_err;

  modport master (
    output wb_en, wb_addr, wb_data, wb_ld_sel,
    output ld_issue, ld_issue_addr, flush,
    output rs1_addr, rs2_addr,
    input  rs1_data, rs2_data, stall, pending, sb_err
  );

  modport slave (
    input  wb_en, wb_addr, wb_data, wb_ld_sel,
    input  ld_issue, ld_issue_addr, flush,
    input  rs1_addr, rs2_addr,
    output rs1_data, rs2_data, stall, pending, sb_err
  );
endinterface

// File: rtl/regfile_wb_sb.sv
// regfile_wb_sb: write-back register file with a per-register load
// scoreboard. Two combinational read ports, one write port, and a sticky
// error flag for load write-backs that were never issued.
// Optional macro REG_BYPASS_EN: same-cycle write-through on the read ports
// and no stall on a register whose load is completing this cycle.
module regfile_wb_sb #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3
) (
  input logic             clk,
  input logic             rst_n,
  regfile_wb_sb_if.slave  bus
);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] pend_q, pend_d;
  logic                err_q, err_d;

  logic [NUM_REGS-1:0] wr_sel, ld_clr, ld_set;
  logic [NUM_REGS-1:0] rs1_dec, rs2_dec;
  logic                unexpected_ld;

  // One-hot decode of an index; indices beyond NUM_REGS decode to all zero,
  // which makes out-of-range reads return 0 and writes/sets do nothing.
  function automatic logic [NUM_REGS-1:0] decode(input logic [ADDR_W-1:0] a);
    logic [NUM_REGS-1:0] d;
    d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      d[i] = (a == ADDR_W'(i));
    end
    return d;
  endfunction

  // Per-register write, load-complete and load-issue select lines
  always_comb begin
    wr_sel  = bus.wb_en ? decode(bus.wb_addr) : '0;
    ld_clr  = bus.wb_ld_sel ? wr_sel : '0;
    ld_set  = bus.ld_issue ? decode(bus.ld_issue_addr) : '0;
    rs1_dec = decode(bus.rs1_addr);
    rs2_dec = decode(bus.rs2_addr);
  end

  // Next register contents: only the addressed register changes
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = wr_sel[i] ? bus.wb_data : regs_q[i];
    end
  end

  // Scoreboard next state: flush and load completion clear, issue sets last
  always_comb begin
    pend_d        = ld_set | (pend_q & ~ld_clr & {NUM_REGS{~bus.flush}});
    unexpected_ld = bus.wb_en && bus.wb_ld_sel && ((pend_q & ld_clr) == '0);
    err_d         = err_q | (unexpected_ld & ~bus.flush);
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      pend_q <= '0;
      err_q  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      pend_q <= pend_d;
      err_q  <= err_d;
    end
  end

  // Read ports, optionally forwarding the write in flight
  always_comb begin
    bus.rs1_data = '0;
    bus.rs2_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rs1_dec[i]) bus.rs1_data = regs_q[i];
      if (rs2_dec[i]) bus.rs2_data = regs_q[i];
    end
`ifdef REG_BYPASS_EN
    if ((rs1_dec & wr_sel) != '0) bus.rs1_data = bus.wb_data;
    if ((rs2_dec & wr_sel) != '0) bus.rs2_data = bus.wb_data;
`endif
  end

  // Stall when either source is still waiting for its load
  always_comb begin
`ifdef REG_BYPASS_EN
    bus.stall = (((rs1_dec | rs2_dec) & pend_q & ~ld_clr) != '0);
`else
    bus.stall = (((rs1_dec | rs2_dec) & pend_q) != '0);
`endif
    bus.pending = pend_q;
    bus.sb_err  = err_q;
  end

endmodule

// File: tb/tb_regfile_wb_sb.sv
// Directed, table-driven bench for regfile_wb_sb plus hand-written
// sequences for same-cycle read, sticky error and asynchronous reset.
module tb_regfile_wb_sb;

  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 8;
  localparam int ADDR_W   = 3;

  logic clk;
  logic rst_n;

  int compared;
  int mismatched;

  regfile_wb_sb_if #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) bus ();

  regfile_wb_sb #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string           name;
    logic            wbEn;
    logic [2:0]      wbAddr;
    logic [15:0]     wbData;
    logic            wbLdSel;
    logic            ldIssue;
    logic [2:0]      ldAddr;
    logic            flush;
    logic [2:0]      rs1;
    logic [2:0]      rs2;
    logic [15:0]     expRs1;
    logic [15:0]     expRs2;
    logic            expStall;
    logic [7:0]      expPend;
    logic            expErr;
  } vec_t;

  vec_t vecs[17];

  // Compare all visible outputs against one expected set
  task automatic checkOutput(input string name, input logic [15:0] eRs1,
                             input logic [15:0] eRs2, input logic eStall,
                             input logic [7:0] ePend, input logic eErr);
    compared++;
    if (bus.rs1_data !== eRs1 || bus.rs2_data !== eRs2 || bus.stall !== eStall ||
        bus.pending !== ePend || bus.sb_err !== eErr) begin
      mismatched++;
      $display("[TB] FAIL %s: got rs1=%h rs2=%h stall=%b pend=%h err=%b, want rs1=%h rs2=%h stall=%b pend=%h err=%b",
               name, bus.rs1_data, bus.rs2_data, bus.stall, bus.pending, bus.sb_err,
               eRs1, eRs2, eStall, ePend, eErr);
    end
  endtask

  task automatic idleInputs();
    bus.wb_en         = 1'b0;
    bus.wb_addr       = '0;
    bus.wb_data       = '0;
    bus.wb_ld_sel     = 1'b0;
    bus.ld_issue      = 1'b0;
    bus.ld_issue_addr = '0;
    bus.flush         = 1'b0;
  endtask

  // Drive one vector for one clock edge, then drop strobes so the sample
  // reflects committed state only
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    bus.wb_en         = v.wbEn;
    bus.wb_addr       = v.wbAddr;
    bus.wb_data       = v.wbData;
    bus.wb_ld_sel     = v.wbLdSel;
    bus.ld_issue      = v.ldIssue;
    bus.ld_issue_addr = v.ldAddr;
    bus.flush         = v.flush;
    bus.rs1_addr      = v.rs1;
    bus.rs2_addr      = v.rs2;
    @(posedge clk);
    #1;
    idleInputs();
    #1;
  endtask

  function automatic vec_t mk(input string n, input logic we, input logic [2:0] wa,
                              input logic [15:0] wd, input logic ls, input logic li,
                              input logic [2:0] la, input logic fl, input logic [2:0] r1,
                              input logic [2:0] r2, input logic [15:0] e1, input logic [15:0] e2,
                              input logic es, input logic [7:0] ep, input logic ee);
    vec_t v;
    v.name = n; v.wbEn = we; v.wbAddr = wa; v.wbData = wd; v.wbLdSel = ls;
    v.ldIssue = li; v.ldAddr = la; v.flush = fl; v.rs1 = r1; v.rs2 = r2;
    v.expRs1 = e1; v.expRs2 = e2; v.expStall = es; v.expPend = ep; v.expErr = ee;
    return v;
  endfunction

  initial begin
    compared   = 0;
    mismatched = 0;

    //            name            we wa  wdata    ls li la fl r1 r2  expRs1   expRs2   st pend   err
    vecs[0]  = mk("alu_r2",       1, 2, 16'hBEEF, 0, 0, 0, 0, 2, 5, 16'hBEEF, 16'h0000, 0, 8'h00, 0);
    vecs[1]  = mk("alu_r5",       1, 5, 16'h0101, 0, 0, 0, 0, 2, 5, 16'hBEEF, 16'h0101, 0, 8'h00, 0);
    vecs[2]  = mk("ld_issue_r4",  0, 0, 16'h0000, 0, 1, 4, 0, 2, 4, 16'hBEEF, 16'h0000, 1, 8'h10, 0);
    vecs[3]  = mk("ld_wb_r4",     1, 4, 16'h1234, 1, 0, 0, 0, 2, 4, 16'hBEEF, 16'h1234, 0, 8'h00, 0);
    vecs[4]  = mk("ld_issue_r6",  0, 0, 16'h0000, 0, 1, 6, 0, 6, 4, 16'h0000, 16'h1234, 1, 8'h40, 0);
    vecs[5]  = mk("set_wins_r6",  1, 6, 16'h00AA, 1, 1, 6, 0, 6, 4, 16'h00AA, 16'h1234, 1, 8'h40, 0);
    vecs[6]  = mk("alu_on_pend",  1, 6, 16'h7777, 0, 0, 0, 0, 6, 4, 16'h7777, 16'h1234, 1, 8'h40, 0);
    vecs[7]  = mk("reissue_r6",   0, 0, 16'h0000, 0, 1, 6, 0, 6, 4, 16'h7777, 16'h1234, 1, 8'h40, 0);
    vecs[8]  = mk("ld_wb_r6",     1, 6, 16'h0BB0, 1, 0, 0, 0, 6, 4, 16'h0BB0, 16'h1234, 0, 8'h00, 0);
    vecs[9]  = mk("ld_issue_r2",  0, 0, 16'h0000, 0, 1, 2, 0, 2, 3, 16'hBEEF, 16'h0000, 1, 8'h04, 0);
    vecs[10] = mk("ld_issue_r3",  0, 0, 16'h0000, 0, 1, 3, 0, 2, 3, 16'hBEEF, 16'h0000, 1, 8'h0C, 0);
    vecs[11] = mk("flush",        0, 0, 16'h0000, 0, 0, 0, 1, 2, 3, 16'hBEEF, 16'h0000, 0, 8'h00, 0);
    vecs[12] = mk("flush_issue",  0, 0, 16'h0000, 0, 1, 7, 1, 7, 3, 16'h0000, 16'h0000, 1, 8'h80, 0);
    vecs[13] = mk("ld_wb_r7",     1, 7, 16'h0007, 1, 0, 0, 0, 7, 3, 16'h0007, 16'h0000, 0, 8'h00, 0);
    vecs[14] = mk("flush_mask_e", 1, 3, 16'h3333, 1, 0, 0, 1, 2, 3, 16'hBEEF, 16'h3333, 0, 8'h00, 0);
    vecs[15] = mk("unexp_ld_wb",  1, 2, 16'h2222, 1, 0, 0, 0, 2, 3, 16'h2222, 16'h3333, 0, 8'h00, 1);
    vecs[16] = mk("alu_no_err",   1, 0, 16'h00F0, 0, 0, 0, 0, 0, 3, 16'h00F0, 16'h3333, 0, 8'h00, 1);

    idleInputs();
    bus.rs1_addr = 3'd3;
    bus.rs2_addr = 3'd5;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("reset_state", 16'h0000, 16'h0000, 1'b0, 8'h00, 1'b0);

    // Same-cycle view of an ALU write before the edge commits it
    @(negedge clk);
    bus.wb_en    = 1'b1;
    bus.wb_addr  = 3'd1;
    bus.wb_data  = 16'hC0DE;
    bus.rs1_addr = 3'd1;
    #1;
`ifdef REG_BYPASS_EN
    checkOutput("same_cycle_rd", 16'hC0DE, 16'h0000, 1'b0, 8'h00, 1'b0);
`else
    checkOutput("same_cycle_rd", 16'h0000, 16'h0000, 1'b0, 8'h00, 1'b0);
`endif
    @(posedge clk);
    #1;
    idleInputs();
    #1;
    checkOutput("next_cycle_rd", 16'hC0DE, 16'h0000, 1'b0, 8'h00, 1'b0);

    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i].name, vecs[i].expRs1, vecs[i].expRs2, vecs[i].expStall,
                  vecs[i].expPend, vecs[i].expErr);
    end

    // Error flag holds through idle cycles, then clears on reset
    repeat (10) @(posedge clk);
    #1;
    checkOutput("err_sticky", 16'h00F0, 16'h3333, 1'b0, 8'h00, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
    checkOutput("err_cleared", 16'h0000, 16'h0000, 1'b0, 8'h00, 1'b0);

    // Asynchronous reset between edges while a load is outstanding
    applyStimulus(mk("pre_async", 1, 1, 16'h5555, 0, 1, 1, 0, 1, 3,
                     16'h5555, 16'h0000, 1, 8'h02, 0));
    checkOutput("pre_async", 16'h5555, 16'h0000, 1'b1, 8'h02, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", 16'h0000, 16'h0000, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
